// File: rtl/fixflo_host_bridge.sv
// Serial-host bridge: parses command frames from a UART receiver, drives the
// arithmetic units, and returns the captured result/flags as a response frame.
module fixflo_host_bridge #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 1000000,
  parameter logic [7:0]  SYNC_IN       = 8'hA5,
  parameter logic [7:0]  SYNC_OUT      = 8'h5A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] num1,
  output logic [15:0] num2,
  output logic [1:0]  op,
  input  logic [15:0] result,
  input  logic [3:0]  flags,
  output logic        busy,
  output logic        frame_err,
  output logic        rx_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_D0, S_D1, S_D2, S_D3, S_EXEC, S_TX
  } state_t;

  localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  state_t      state;
  logic [31:0] to_cnt;
  logic [7:0]  settle_cnt;
  logic [1:0]  tx_idx;
  logic [7:0]  rsp_status;
  logic [7:0]  rsp_hi;
  logic [7:0]  rsp_lo;
  logic [7:0]  next_tx_byte;

  assign busy = (state != S_IDLE);

  // Byte that follows the one currently presented at index tx_idx.
  always_comb begin
    next_tx_byte = rsp_lo;
    case (tx_idx)
      2'd0:    next_tx_byte = rsp_status;
      2'd1:    next_tx_byte = rsp_hi;
      default: next_tx_byte = rsp_lo;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      to_cnt     <= '0;
      settle_cnt <= '0;
      tx_idx     <= '0;
      rsp_status <= '0;
      rsp_hi     <= '0;
      rsp_lo     <= '0;
      num1       <= '0;
      num2       <= '0;
      op         <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid && rx_data == SYNC_IN) begin
            state  <= S_CMD;
            to_cnt <= '0;
          end
        end
        S_CMD, S_D0, S_D1, S_D2, S_D3: begin
          if (rx_valid) begin
            to_cnt <= '0;
            case (state)
              S_CMD: begin
                if (rx_data[7:2] != 6'd0) begin
                  // Bad command: answer immediately with the error frame.
                  frame_err  <= 1'b1;
                  rsp_status <= 8'h80;
                  rsp_hi     <= 8'h00;
                  rsp_lo     <= 8'h00;
                  tx_data    <= SYNC_OUT;
                  tx_valid   <= 1'b1;
                  tx_idx     <= '0;
                  state      <= S_TX;
                end else begin
                  op    <= rx_data[1:0];
                  state <= S_D0;
                end
              end
              S_D0: begin
                num1[15:8] <= rx_data;
                state      <= S_D1;
              end
              S_D1: begin
                num1[7:0] <= rx_data;
                state     <= S_D2;
              end
              S_D2: begin
                num2[15:8] <= rx_data;
                state      <= S_D3;
              end
              default: begin
                num2[7:0]  <= rx_data;
                settle_cnt <= '0;
                state      <= S_EXEC;
              end
            endcase
          end else if (to_cnt == TIMEOUT_LAST) begin
            frame_err <= 1'b1;
            to_cnt    <= '0;
            state     <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        S_EXEC: begin
          if (rx_valid) rx_overrun <= 1'b1;
          if (settle_cnt == SETTLE_LAST) begin
            rsp_status <= {4'b0000, flags};
            rsp_hi     <= result[15:8];
            rsp_lo     <= result[7:0];
            tx_data    <= SYNC_OUT;
            tx_valid   <= 1'b1;
            tx_idx     <= '0;
            state      <= S_TX;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        S_TX: begin
          if (rx_valid) rx_overrun <= 1'b1;
          if (tx_valid && tx_ready) begin
            if (tx_idx == 2'd3) begin
              tx_valid <= 1'b0;
              state    <= S_IDLE;
            end else begin
              tx_idx  <= tx_idx + 2'd1;
              tx_data <= next_tx_byte;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixflo_host_bridge.sv
// Scoreboard bench for fixflo_host_bridge: directed frames push expected
// response bytes; a negedge monitor pops and compares on each tx transfer.
module tb_fixflo_host_bridge;

  localparam int unsigned SETTLE = 3;
  localparam int unsigned TMO    = 40;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] num1;
  logic [15:0] num2;
  logic [1:0]  op;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        busy;
  logic        frame_err;
  logic        rx_overrun;

  fixflo_host_bridge #(
    .SETTLE_CYCLES(SETTLE),
    .TIMEOUT(TMO),
    .SYNC_IN(8'hA5),
    .SYNC_OUT(8'h5A)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .num1(num1), .num2(num2), .op(op),
    .result(result), .flags(flags),
    .busy(busy), .frame_err(frame_err), .rx_overrun(rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int stall_len = 0;
  int rcnt = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] popped;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: stability during stalls, and scoreboard compare on transfer.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else if (tx_valid) begin
      if (prev_stall) check("tx_hold", tx_data, prev_data);
      if (tx_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_unexpected: got %0h expected no byte", tx_data);
        end else begin
          popped = exp_q.pop_front();
          check("tx_byte", tx_data, popped);
        end
      end
      prev_stall = !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Transmitter model: stall_len cycles of tx_ready low before each accept.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!tx_valid) begin
        tx_ready = (stall_len == 0);
        rcnt = 0;
      end else if (rcnt < stall_len) begin
        tx_ready = 1'b0;
        rcnt++;
      end else begin
        tx_ready = 1'b1;
        rcnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] a, input logic [15:0] b);
    send(8'hA5); send(cmd);
    send(a[15:8]); send(a[7:0]);
    send(b[15:8]); send(b[7:0]);
  endtask

  task automatic push_rsp(input logic [7:0] s, input logic [15:0] r);
    exp_q.push_back(8'h5A);
    exp_q.push_back(s);
    exp_q.push_back(r[15:8]);
    exp_q.push_back(r[7:0]);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    check("wait_idle", busy, 0);
    check("rsp_len", exp_q.size(), 0);
  endtask

  task automatic wait_tx();
    int c = 0;
    while (!tx_valid && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    check("wait_tx", tx_valid, 1);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_num1"}, num1, 0);
    check({tag, "_num2"}, num2, 0);
    check({tag, "_op"}, op, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_overrun"}, rx_overrun, 0);
  endtask

  initial begin
    int c;
    logic saw_tx;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; result = '0; flags = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    reset_check("reset");

    // Float add frame, latency from last operand byte to first tx_valid.
    result = 16'h4000; flags = 4'h0;
    push_rsp(8'h00, 16'h4000);
    send_frame(8'h00, 16'h3C00, 16'h3C00);
    check("a_num1", num1, 16'h3C00);
    check("a_num2", num2, 16'h3C00);
    check("a_op", op, 0);
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (!tx_valid && c < 20);
    check("a_latency", c, SETTLE);
    wait_idle();

    // Fixed mult with transmitter stalls; inputs change after capture.
    stall_len = 5;
    result = 16'h1234; flags = 4'b1001;
    push_rsp(8'h09, 16'h1234);
    send_frame(8'h03, 16'h7FFF, 16'h0002);
    check("b_op", op, 3);
    check("b_num1", num1, 16'h7FFF);
    check("b_num2", num2, 16'h0002);
    wait_tx();
    result = 16'hDEAD; flags = 4'h0;
    wait_idle();
    stall_len = 0;

    // Bad command byte.
    push_rsp(8'h80, 16'h0000);
    send(8'hA5);
    send(8'h14);
    check("c_frame_err", frame_err, 1);
    check("c_op_kept", op, 3);
    check("c_tx_valid", tx_valid, 1);
    @(posedge clk); #1;
    check("c_err_pulse", frame_err, 0);
    wait_idle();
    send(8'h3C); send(8'h00); send(8'h11); send(8'h22);
    check("c_ignored", busy, 0);

    // Inter-byte timeout after a partial frame.
    send(8'hA5); send(8'h01); send(8'h12);
    check("d_num1_hi", num1[15:8], 8'h12);
    check("d_op", op, 1);
    c = 0; saw_tx = 1'b0;
    do begin
      @(posedge clk); #1;
      c++;
      if (tx_valid) saw_tx = 1'b1;
    end while (!frame_err && c < int'(TMO) + 5);
    check("d_timeout_cycles", c, TMO);
    check("d_busy", busy, 0);
    check("d_no_tx", saw_tx, 0);
    check("d_num1_hi_kept", num1[15:8], 8'h12);

    // Overrun during EXEC; response and following frame unaffected.
    check("e_overrun_clear", rx_overrun, 0);
    result = 16'h5555; flags = 4'b0100;
    push_rsp(8'h04, 16'h5555);
    send_frame(8'h02, 16'h1111, 16'h2222);
    send(8'hFF);
    check("e_overrun_set", rx_overrun, 1);
    wait_idle();
    check("e_overrun_sticky", rx_overrun, 1);
    result = 16'h0001; flags = 4'h0;
    push_rsp(8'h00, 16'h0001);
    send_frame(8'h01, 16'hABCD, 16'h0F0F);
    check("e_next_op", op, 1);
    wait_idle();
    check("e_overrun_still", rx_overrun, 1);
    check("e_num1_held", num1, 16'hABCD);

    // Reset while in D2.
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    reset_check("rst_d2");

    // Reset while in TX (held off by a stalled transmitter).
    stall_len = 3;
    result = 16'h7777; flags = 4'h1;
    push_rsp(8'h01, 16'h7777);
    send_frame(8'h00, 16'h0102, 16'h0304);
    wait_tx();
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    reset_check("rst_tx");
    saw_tx = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (tx_valid) saw_tx = 1'b1;
    end
    check("rst_tx_quiet", saw_tx, 0);
    stall_len = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
